// File: rtl/demux_scan_ctrl.sv
// Sequences a captured 4-bit pattern onto a 1:4 demux (d, s), holding each channel DWELL cycles.
// Latency: the first channel appears one cycle after start is sampled. All outputs are registered.
// No backpressure; stop aborts a scan. DEMUX_SCAN_SKIP_EN: visit only the channels whose pattern bit is set.
module demux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] pattern,
  input  logic       loop,
  input  logic       stop,
  output logic       d,
  output logic [1:0] s,
  output logic       busy,
  output logic       ch_strobe,
  output logic       done,
  output logic [7:0] frame_cnt
);

  if (DWELL < 1 || DWELL > (2 ** CNT_W)) begin : g_bad_dwell
    $error("demux_scan_ctrl: DWELL must be in 1..2**CNT_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  state_t           state, state_nxt;
  logic [1:0]       ch, ch_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       pattern_reg, pattern_nxt;
  logic [7:0]       frame_nxt;

  logic             d_nxt;
  logic [1:0]       s_nxt;
  logic             busy_nxt;
  logic             ch_strobe_nxt;
  logic             done_nxt;

  // Channel-order helpers: where a scan starts, where it goes next, and where a frame ends.
  logic [1:0]       cap_first_ch;
  logic [1:0]       reg_first_ch;
  logic [1:0]       next_ch;
  logic             last_ch;
  logic             start_empty;
  logic             scan_empty;
  logic             nxt_empty;

`ifdef DEMUX_SCAN_SKIP_EN
  always_comb begin
    cap_first_ch = 2'd0;
    reg_first_ch = 2'd0;
    next_ch      = ch;
    last_ch      = 1'b1;
    // Walking downwards leaves the lowest qualifying channel in each result.
    for (int i = 3; i >= 0; i--) begin
      if (pattern[i]) cap_first_ch = 2'(i);
      if (pattern_reg[i]) reg_first_ch = 2'(i);
      if (pattern_reg[i] && (i > int'(ch))) begin
        next_ch = 2'(i);
        last_ch = 1'b0;
      end
    end
  end

  assign start_empty = (pattern == 4'b0000);
  assign scan_empty  = (pattern_reg == 4'b0000);
  assign nxt_empty   = (pattern_nxt == 4'b0000);
`else
  assign cap_first_ch = 2'd0;
  assign reg_first_ch = 2'd0;
  assign next_ch      = ch + 2'd1;
  assign last_ch      = (ch == 2'd3);
  assign start_empty  = 1'b0;
  assign scan_empty   = 1'b0;
  assign nxt_empty    = 1'b0;
`endif

  logic dwell_end;
  logic frame_end;

  assign dwell_end = (cnt == LAST_CNT);
  // An all-zero pattern in skip mode has no channels, so every SCAN cycle closes a frame.
  assign frame_end = (dwell_end && last_ch) || scan_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch          <= 2'd0;
      cnt         <= '0;
      pattern_reg <= 4'b0000;
      frame_cnt   <= 8'd0;
      d           <= 1'b0;
      s           <= 2'b00;
      busy        <= 1'b0;
      ch_strobe   <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      ch          <= ch_nxt;
      cnt         <= cnt_nxt;
      pattern_reg <= pattern_nxt;
      frame_cnt   <= frame_nxt;
      d           <= d_nxt;
      s           <= s_nxt;
      busy        <= busy_nxt;
      ch_strobe   <= ch_strobe_nxt;
      done        <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ch_nxt      = ch;
    cnt_nxt     = cnt;
    pattern_nxt = pattern_reg;
    frame_nxt   = frame_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          pattern_nxt = pattern;
          ch_nxt      = cap_first_ch;
          cnt_nxt     = '0;
          if (start_empty) begin
            frame_nxt = frame_cnt + 8'd1;
            state_nxt = loop ? SCAN : DONE;
          end else begin
            state_nxt = SCAN;
          end
        end
      end
      SCAN: begin
        if (stop) begin
          state_nxt = IDLE;
          ch_nxt    = 2'd0;
          cnt_nxt   = '0;
        end else if (frame_end) begin
          frame_nxt = frame_cnt + 8'd1;
          ch_nxt    = reg_first_ch;
          cnt_nxt   = '0;
          state_nxt = loop ? SCAN : DONE;
        end else if (dwell_end) begin
          ch_nxt  = next_ch;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ch_nxt    = 2'd0;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        ch_nxt    = 2'd0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they register alongside it.
  always_comb begin
    busy_nxt      = (state_nxt == SCAN);
    done_nxt      = (state_nxt == DONE);
    s_nxt         = busy_nxt ? ch_nxt : 2'b00;
    d_nxt         = busy_nxt && pattern_nxt[ch_nxt];
    ch_strobe_nxt = busy_nxt && (cnt_nxt == '0) && !nxt_empty;
  end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Directed bench for demux_scan_ctrl (DWELL=4): a vector table for the basic frame, then hand-written multi-cycle sequences.
module tb_demux_scan_ctrl;
  localparam int DWELL = 4;
  localparam int CNT_W = 3;

  logic       clk = 1'b0;
  logic       rst_n, start, loop, stop;
  logic [3:0] pattern;
  logic       d, busy, ch_strobe, done;
  logic [1:0] s;
  logic [7:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst_n;
    logic        start;
    logic        loop;
    logic        stop;
    logic [3:0]  pattern;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  demux_scan_ctrl #(.DWELL(DWELL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .loop(loop), .stop(stop),
    .d(d), .s(s), .busy(busy), .ch_strobe(ch_strobe), .done(done), .frame_cnt(frame_cnt)
  );

  // Expected outputs packed as {d, s, busy, ch_strobe, done, frame_cnt}.
  function automatic logic [13:0] idle_exp(input logic [7:0] frame);
    return {1'b0, 2'b00, 1'b0, 1'b0, 1'b0, frame};
  endfunction

  function automatic logic [13:0] done_exp(input logic [7:0] frame);
    return {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, frame};
  endfunction

  // Cycle i of a scan that visits all four channels in order.
  function automatic logic [13:0] scan_exp(input logic [3:0] pat, input int i, input logic [7:0] frame);
    int c;
    c = (i / DWELL) % 4;
    return {pat[c], 2'(c), 1'b1, ((i % DWELL) == 0), 1'b0, frame};
  endfunction

  task automatic tick(input logic rn, input logic st, input logic lp, input logic sp, input logic [3:0] pat);
    rst_n   = rn;
    start   = st;
    loop    = lp;
    stop    = sp;
    pattern = pat;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [13:0] exp);
    logic [13:0] act;
    act = {d, s, busy, ch_strobe, done, frame_cnt};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got d=%0b s=%0d busy=%0b strobe=%0b done=%0b frame=%0d, want d=%0b s=%0d busy=%0b strobe=%0b done=%0b frame=%0d",
               name, act[13], act[12:11], act[10], act[9], act[8], act[7:0],
               exp[13], exp[12:11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic add(input logic rn, input logic st, input logic lp, input logic sp,
                     input logic [3:0] pat, input logic [13:0] exp);
    vec_t v;
    v.rst_n = rn; v.start = st; v.loop = lp; v.stop = sp; v.pattern = pat; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; loop = 1'b0; stop = 1'b0; pattern = 4'b0000;

`ifndef DEMUX_SCAN_SKIP_EN
    // Basic one-shot frame, pattern 1011: each row's inputs are sampled on one edge, outputs checked after it.
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, idle_exp(8'd0));
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, idle_exp(8'd0));
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, idle_exp(8'd0));
    add(1'b1, 1'b1, 1'b0, 1'b0, 4'b1011, scan_exp(4'b1011, 0, 8'd0));
    for (int i = 1; i < 4 * DWELL; i++)
      add(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, scan_exp(4'b1011, i, 8'd0));
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, done_exp(8'd1));
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, idle_exp(8'd1));

    for (int r = 0; r < vecs.size(); r++) begin
      tick(vecs[r].rst_n, vecs[r].start, vecs[r].loop, vecs[r].stop, vecs[r].pattern);
      chk($sformatf("oneshot_row%0d", r), vecs[r].exp);
    end

    // Loop for three frames; loop drops mid third frame so its end goes to DONE.
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk("loop_reset", idle_exp(8'd0));
    tick(1'b1, 1'b1, 1'b1, 1'b0, 4'b0101);
    for (int i = 0; i < 12 * DWELL; i++) begin
      chk($sformatf("loop_cyc%0d", i), scan_exp(4'b0101, i, 8'(i / (4 * DWELL))));
      tick(1'b1, 1'b0, (i < 10 * DWELL), 1'b0, 4'b0101);
    end
    chk("loop_done", done_exp(8'd3));
    tick(1'b1, 1'b0, 1'b0, 1'b0, 4'b0101);
    chk("loop_idle", idle_exp(8'd3));

    // Abort in cycle 6 of a scan.
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stop_cyc%0d", i), scan_exp(4'b1111, i, 8'd0));
      tick(1'b1, 1'b0, 1'b0, (i == 5), 4'b1111);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stop_idle%0d", i), idle_exp(8'd0));
      tick(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111);
    end

    // Stop on the frame-end cycle beats the loop restart and the frame count.
    tick(1'b1, 1'b1, 1'b1, 1'b0, 4'b1111);
    for (int i = 0; i < 4 * DWELL; i++) begin
      chk($sformatf("stopend_cyc%0d", i), scan_exp(4'b1111, i, 8'd0));
      tick(1'b1, 1'b0, 1'b1, (i == 4 * DWELL - 1), 4'b1111);
    end
    chk("stopend_idle", idle_exp(8'd0));

    // Reset at cycle 10 of a scan after one completed frame.
    tick(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111);
    repeat (4 * DWELL) tick(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111);
    chk("rst_prev_done", done_exp(8'd1));
    tick(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("rst_cyc%0d", i), scan_exp(4'b1111, i, 8'd1));
      tick((i != 9), 1'b0, 1'b1, 1'b0, 4'b1111);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_idle%0d", i), idle_exp(8'd0));
      tick(1'b1, 1'b0, 1'b1, 1'b0, 4'b1111);
    end

    // start during SCAN and DONE is ignored; a new pattern does not leak into the scan.
    tick(1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
    for (int i = 0; i < 4 * DWELL; i++) begin
      chk($sformatf("ign_cyc%0d", i), scan_exp(4'b1011, i, 8'd0));
      tick(1'b1, (i == 2 || i == 7 || i == 12), 1'b0, 1'b0, 4'b0100);
    end
    chk("ign_done", done_exp(8'd1));
    tick(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111);
    chk("ign_start_in_done", idle_exp(8'd1));
    tick(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111);
    chk("restart_after_done", scan_exp(4'b1111, 0, 8'd1));
    tick(1'b1, 1'b0, 1'b0, 1'b1, 4'b1111);
    chk("restart_stopped", idle_exp(8'd1));
`else
    // Skip mode: pattern 1001 visits only channels 0 and 3.
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk("skip_reset", idle_exp(8'd0));
    tick(1'b1, 1'b1, 1'b0, 1'b0, 4'b1001);
    for (int i = 0; i < 2 * DWELL; i++) begin
      chk($sformatf("skip_cyc%0d", i),
          {1'b1, ((i < DWELL) ? 2'd0 : 2'd3), 1'b1, ((i % DWELL) == 0), 1'b0, 8'd0});
      tick(1'b1, 1'b0, 1'b0, 1'b0, 4'b1001);
    end
    chk("skip_done", done_exp(8'd1));
    tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    chk("skip_empty_done", done_exp(8'd1));
    tick(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk("skip_empty_idle", idle_exp(8'd1));
    tick(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    chk("skip_empty_loop0", {1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd2});
    tick(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    chk("skip_empty_loop1", {1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd3});
    tick(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk("skip_empty_loop_done", done_exp(8'd4));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_scan_ctrl.md
Name: demux_scan_ctrl

Overview:
Upstream sequencer for the 1-to-4 demultiplexer stage. It captures a 4-bit channel pattern and drives the demux data input `d` and select `s[1:0]`, visiting channels 0 to 3 in order. Each channel is held for a programmable dwell time. It supports one-shot and continuous (loop) scanning, abort, and a frame counter for the downstream/debug logic.

Parameters:
- DWELL, 4, cycles each channel is held (legal range 1..2**CNT_W)
- CNT_W, 3, width of the dwell counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- start  input  1  begin scan; sampled only in IDLE
- pattern  input  4  bit i = data value routed to channel i; captured on accepted start
- loop  input  1  1 = restart at channel 0 after channel 3; sampled at each frame end
- stop  input  1  abort scan; sampled in SCAN
- d  output  1  demux data input
- s  output  2  demux select
- busy  output  1  high while in SCAN
- ch_strobe  output  1  1-cycle pulse on the first cycle of each channel dwell
- done  output  1  1-cycle pulse after a non-aborted final frame
- frame_cnt  output  8  completed-frame counter

Behaviour:
- Single clock domain. All outputs are registered.
- Reset is synchronous and active-low: when `rst_n` = 0 at a `clk` rising edge, the block goes to IDLE and sets d=0, s=00, busy=0, ch_strobe=0, done=0, frame_cnt=0, pattern_reg=0, dwell counter=0.
- Reset mid-scan takes effect on that edge. There is no done pulse and no frame_cnt increment.
- States: IDLE, SCAN, DONE.
- IDLE:
  - Outputs: d=0, s=00, busy=0.
  - If start=1, capture pattern into pattern_reg, set ch=0 and counter=0, and go to SCAN.
  - The first SCAN cycle is the cycle after start is sampled (latency 1). ch_strobe=1 in that cycle.
- SCAN:
  - Outputs: s=ch, d=pattern_reg[ch], busy=1.
  - The counter increments each cycle. The last dwell cycle is counter==DWELL-1.
  - At the last dwell cycle with ch<3: ch increments, counter=0, and ch_strobe pulses in the next cycle.
  - At the last dwell cycle with ch==3:
    - frame_cnt increments, wrapping 255 to 0.
    - If loop=1: ch=0, counter=0, and ch_strobe pulses next cycle. pattern_reg is kept and not re-captured.
    - If loop=0: go to DONE.
  - start is ignored during SCAN. A new pattern value does not affect a scan in progress.
  - stop=1 in any SCAN cycle means the next state is IDLE, with no done and no frame_cnt increment.
  - stop has priority over the frame-end transition in the same cycle.
- DONE (one cycle): d=0, s=00, busy=0, done=1, then go to IDLE.
  - start is ignored in DONE. The earliest new start is sampled in the following IDLE cycle.
- DWELL=1: each channel is held one cycle, and ch_strobe is high every SCAN cycle.
- Frame length is 4*DWELL cycles. With loop=0, start-to-done is 4*DWELL+1 cycles.

Optional Feature:
Macro: DEMUX_SCAN_SKIP_EN.
- Defined:
  - Channels whose pattern_reg bit is 0 are skipped. Only channels with bit=1 are visited, in ascending order, each held for DWELL cycles.
  - The frame ends after the highest set channel.
  - pattern=0000 on start: go directly to DONE in the next cycle, with frame_cnt +1 and no SCAN cycles.
  - loop with pattern 0000 alternates: DONE is not entered, and frame_cnt increments every cycle while busy=1 and d=0.
- Not defined: all 4 channels are visited regardless of pattern. The skip logic is absent from the netlist.

Test Plan:
1. Reset, then start=1 for 1 cycle with pattern=1011, loop=0, DWELL=4 (start sampled at cycle 0):
   - cycles 1-4: s=00, d=1.
   - cycles 5-8: s=01, d=1.
   - cycles 9-12: s=10, d=0.
   - cycles 13-16: s=11, d=1.
   - cycle 17: done=1, busy=0, frame_cnt=1.
   - ch_strobe at cycles 1, 5, 9, 13.
2. loop=1, pattern=0101, run 3 frames, then drop loop:
   - s sequence 00,01,10,11 repeats with d pattern 1,0,1,0.
   - frame_cnt=3 after the third frame; exactly one done, after the frame in which loop was sampled 0.
3. stop=1 at cycle 6 of a scan: cycle 7 is IDLE with d=0, s=00, busy=0; no done; frame_cnt unchanged.
4. rst_n=0 at cycle 10 mid-scan: the next cycle has all outputs 0, frame_cnt=0, and the scan does not resume.
5. Start pulsed during SCAN with a different pattern: ignored, and outputs still follow the original pattern.
6. With DEMUX_SCAN_SKIP_EN, pattern=1001:
   - only s=00 (cycles 1-4) and s=11 (cycles 5-8) are visited; done at 9.
   - pattern=0000: done at cycle 1, frame_cnt=1.
